touch_poll_sequencer: RTL and testbench

// Upstream command sequencer for the I2C master that reads the capacitive touch controller.

---
 rtl/touch_poll_sequencer.sv | 167 ++++++++++++++++
 tb/tb_touch_poll_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_poll_sequencer.sv
// Poll sequencer for the capacitive touch controller: issues a five-register read burst per
// poll interval through an I2C master, assembles count/X/Y and publishes them atomically.
module touch_poll_sequencer #(
  parameter int unsigned POLL_PERIOD    = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter logic [6:0]  DEV_ADDR       = 7'h38,
  parameter logic [7:0]  FIRST_REG      = 8'h02
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  output logic        i2c_trigger_out,
  output logic [7:0]  i2c_reg_out,
  output logic [6:0]  i2c_addr_out,
  input  logic [7:0]  i2c_data_in,
  input  logic        i2c_valid_in,
  output logic [3:0]  touch_count_out,
  output logic [11:0] touch_x_out,
  output logic [11:0] touch_y_out,
  output logic        touch_valid_out,
  output logic        timeout_out
);

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_POLL,
    S_ISSUE,
    S_WAIT_DATA,
    S_NEXT,
    S_PUBLISH
  } state_e;

  state_e        state_q;
  logic [PW-1:0] poll_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [2:0]    idx_q;
  logic          trigger_q;
  logic [7:0]    reg_q;
  logic          touch_valid_q;
  logic          timeout_q;
  logic [3:0]    touch_count_q;
  logic [11:0]   touch_x_q;
  logic [11:0]   touch_y_q;

  // Only the low nibble of the status and high-coordinate registers carries data.
  logic [3:0]    st_q;
  logic [3:0]    xh_q;
  logic [7:0]    xl_q;
  logic [3:0]    yh_q;
  logic [7:0]    yl_q;

  logic [3:0]    cnt_d;
  logic [11:0]   x_d;
  logic [11:0]   y_d;

  // The controller reports at most two points; anything larger is a corrupt status byte.
  function automatic logic [3:0] clamp_count(input logic [3:0] status);
    clamp_count = (status > 4'd2) ? 4'd0 : status;
  endfunction

  always_comb begin
    cnt_d = clamp_count(st_q);
    x_d   = touch_x_q;
    y_d   = touch_y_q;
    if (cnt_d != 4'd0) begin
      x_d = {xh_q, xl_q};
      y_d = {yh_q, yl_q};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_WAIT_POLL;
      poll_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      idx_q         <= '0;
      trigger_q     <= 1'b0;
      reg_q         <= FIRST_REG;
      touch_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      touch_count_q <= '0;
      touch_x_q     <= '0;
      touch_y_q     <= '0;
      st_q          <= '0;
      xh_q          <= '0;
      xl_q          <= '0;
      yh_q          <= '0;
      yl_q          <= '0;
    end else begin
      trigger_q     <= 1'b0;
      touch_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      if (poll_cnt_q != POLL_LAST) poll_cnt_q <= poll_cnt_q + PW'(1);

      case (state_q)
        S_WAIT_POLL: begin
          if (poll_cnt_q == POLL_LAST && enable_in) begin
            poll_cnt_q <= '0;
            idx_q      <= '0;
            reg_q      <= FIRST_REG;
            trigger_q  <= 1'b1;
            tmo_cnt_q  <= '0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
          state_q   <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (i2c_valid_in) begin
            case (idx_q)
              3'd0:    st_q <= i2c_data_in[3:0];
              3'd1:    xh_q <= i2c_data_in[3:0];
              3'd2:    xl_q <= i2c_data_in;
              3'd3:    yh_q <= i2c_data_in[3:0];
              default: yl_q <= i2c_data_in;
            endcase
            state_q <= S_NEXT;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Abandon the whole burst; published values stay as they were.
            timeout_q <= 1'b1;
            st_q      <= '0;
            xh_q      <= '0;
            xl_q      <= '0;
            yh_q      <= '0;
            yl_q      <= '0;
            state_q   <= S_WAIT_POLL;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        S_NEXT: begin
          if (idx_q == 3'd4) begin
            touch_count_q <= cnt_d;
            touch_x_q     <= x_d;
            touch_y_q     <= y_d;
            touch_valid_q <= 1'b1;
            state_q       <= S_PUBLISH;
          end else begin
            idx_q     <= idx_q + 3'd1;
            reg_q     <= FIRST_REG + {5'd0, idx_q} + 8'd1;
            trigger_q <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= S_ISSUE;
          end
        end
        S_PUBLISH: state_q <= S_WAIT_POLL;
        default:   state_q <= S_WAIT_POLL;
      endcase
    end
  end

  assign i2c_trigger_out = trigger_q;
  assign i2c_reg_out     = reg_q;
  assign i2c_addr_out    = DEV_ADDR;
  assign touch_count_out = touch_count_q;
  assign touch_x_out     = touch_x_q;
  assign touch_y_out     = touch_y_q;
  assign touch_valid_out = touch_valid_q;
  assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_touch_poll_sequencer.sv
// Randomized bench for touch_poll_sequencer: a bus responder answers each read and a
// reference model derives the published count/X/Y straight from the returned bytes.
module tb_touch_poll_sequencer;

  localparam int P = 60;
  localparam int T = 16;
  localparam logic [7:0] FR = 8'h02;
  localparam logic [6:0] DA = 7'h38;

  logic        clk = 1'b0;
  logic        rst_in, enable_in, valid_in;
  logic [7:0]  data_in;
  logic        trig, tv, tmo;
  logic [7:0]  reg_out;
  logic [6:0]  addr_out;
  logic [3:0]  cnt_out;
  logic [11:0] x_out, y_out;

  touch_poll_sequencer #(
    .POLL_PERIOD(P), .TIMEOUT_CYCLES(T), .DEV_ADDR(DA), .FIRST_REG(FR)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .enable_in(enable_in),
    .i2c_trigger_out(trig), .i2c_reg_out(reg_out), .i2c_addr_out(addr_out),
    .i2c_data_in(data_in), .i2c_valid_in(valid_in),
    .touch_count_out(cnt_out), .touch_x_out(x_out), .touch_y_out(y_out),
    .touch_valid_out(tv), .timeout_out(tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tv = 0, n_tmo = 0, n_trig = 0;
  int last_start;
  int exp_cnt = 0, exp_x = 0, exp_y = 0;
  logic [7:0] rep [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: what the drawing logic should see after a complete burst of replies.
  task automatic model_publish();
    int c;
    c = rep[0] % 16;
    if (c > 2) c = 0;
    if (c != 0) begin
      exp_x = (rep[1] % 16) * 256 + rep[2];
      exp_y = (rep[3] % 16) * 256 + rep[4];
    end
    exp_cnt = c;
  endtask

  // Published outputs may only move in a touch_valid cycle.
  initial begin
    logic [3:0] pc; logic [11:0] px, py;
    pc = 0; px = 0; py = 0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        pc = 0; px = 0; py = 0;
      end else begin
        if (!tv) begin
          check("hold_cnt", cnt_out, pc);
          check("hold_x", x_out, px);
          check("hold_y", y_out, py);
        end
        pc = cnt_out; px = x_out; py = y_out;
        if (tv)   n_tv++;
        if (tmo)  n_tmo++;
        if (trig) n_trig++;
      end
    end
  end

  task automatic wait_trig(output int tc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3 * P; k++) begin
      @(negedge clk);
      if (trig) begin
        ok = 1'b1;
        break;
      end
    end
    tc = cyc;
    if (!ok) check("trig_wait", 0, 1);
  endtask

  // One burst: gap is the expected distance from last_start to the first trigger (0 = skip).
  task automatic run_seq(input int withhold, input int gap);
    int tc, tv0, tmo0, d, vcyc;
    bit ok;
    tv0 = n_tv; tmo0 = n_tmo;
    for (int i = 0; i < 5; i++) begin
      wait_trig(tc, ok);
      if (!ok) return;
      check("reg", reg_out, FR + i);
      check("addr", addr_out, DA);
      if (i == 0) begin
        if (gap != 0) check("start_gap", tc - last_start, gap);
        last_start = tc;
      end
      if (i == withhold) begin
        for (int k = 0; k < T + 5; k++) begin
          @(negedge clk);
          if (tmo) break;
        end
        check("tmo_lat", cyc - tc, T);
        @(negedge clk);
        check("tmo_pulse", tmo, 0);
        check("tmo_count", n_tmo - tmo0, 1);
        check("tmo_no_tv", n_tv - tv0, 0);
        check("tmo_cnt_keep", cnt_out, exp_cnt);
        check("tmo_x_keep", x_out, exp_x);
        return;
      end
      d = $urandom_range(1, 3);
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        check("trig_pulse", trig, 0);
        check("reg_hold", reg_out, FR + i);
      end
      valid_in = 1'b1; data_in = rep[i]; vcyc = cyc;
      @(negedge clk);
      valid_in = 1'b0; data_in = 8'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      if (tv) break;
      @(negedge clk);
    end
    check("pub_lat", cyc - vcyc, 2);
    model_publish();
    check("cnt", cnt_out, exp_cnt);
    check("x", x_out, exp_x);
    check("y", y_out, exp_y);
    @(negedge clk);
    check("tv_pulse", tv, 0);
    check("tv_count", n_tv - tv0, 1);
    check("no_tmo", n_tmo - tmo0, 0);
  endtask

  initial begin
    int tc, t0;
    bit ok;
    rst_in = 1'b1; enable_in = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt_out, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_tv", tv, 0);
    check("rst_tmo", tmo, 0);
    check("rst_trig", trig, 0);
    check("rst_reg", reg_out, FR);
    check("rst_addr", addr_out, DA);
    rst_in = 1'b0; last_start = cyc;

    rep = '{8'h01, 8'h81, 8'h23, 8'h02, 8'h45};
    run_seq(-1, P);
    check("t1_cnt", cnt_out, 1);
    check("t1_x", x_out, 12'h123);
    check("t1_y", y_out, 12'h245);

    rep = '{8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_seq(-1, P);
    check("t2_x", x_out, 12'h123);

    rep = '{8'h0F, 8'h8A, 8'h55, 8'h0B, 8'h66};
    run_seq(-1, P);
    check("t3_cnt", cnt_out, 0);
    rep = '{8'h02, 8'h8F, 8'hFF, 8'h0F, 8'hFF};
    run_seq(-1, P);
    check("t3_x", x_out, 12'hFFF);

    rep = '{8'h01, 8'h03, 8'h10, 8'h04, 8'h20};
    run_seq(2, P);
    run_seq(-1, P);

    // Reset while the second read of a burst is outstanding.
    rep = '{8'h02, 8'h01, 8'h11, 8'h01, 8'h22};
    wait_trig(tc, ok);
    check("t5_gap", tc - last_start, P);
    @(negedge clk);
    valid_in = 1'b1; data_in = rep[0];
    @(negedge clk);
    valid_in = 1'b0;
    wait_trig(tc, ok);
    check("t5_reg", reg_out, FR + 1);
    @(negedge clk);
    #2 rst_in = 1'b1;
    #1;
    check("t5_cnt", cnt_out, 0);
    check("t5_x", x_out, 0);
    check("t5_y", y_out, 0);
    check("t5_trig", trig, 0);
    check("t5_reg0", reg_out, FR);
    exp_cnt = 0; exp_x = 0; exp_y = 0;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0; last_start = cyc;
    t0 = n_tv;
    repeat (2) @(negedge clk);
    valid_in = 1'b1; data_in = 8'h5A;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_late_ignored", n_tv - t0, 0);
    run_seq(-1, P);

    // Polling held off, then released with the poll counter saturated.
    enable_in = 1'b0; t0 = n_trig;
    repeat (3 * P) @(negedge clk);
    check("en_off_trig", n_trig - t0, 0);
    enable_in = 1'b1; last_start = cyc;
    rep = '{8'h01, 8'h07, 8'h77, 8'h02, 8'h88};
    run_seq(-1, 1);
    run_seq(-1, P);

    for (int s = 0; s < 10; s++) begin
      int wh;
      rep[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
      for (int b = 1; b < 5; b++) rep[b] = 8'($urandom);
      wh = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_seq(wh, P);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
